// File: rtl/sqrt_host_pkg.sv
// Shared types and default widths for the sqrt_host initiator and its result FIFO.
package sqrt_host_pkg;

  localparam int unsigned DefXW = 8;
  localparam int unsigned DefRW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_t;

  typedef struct packed {
    logic [DefXW-1:0] x;
    logic [DefRW-1:0] r;
  } entry_t;

endpackage

// File: rtl/sqrt_host_fifo.sv
// Small synchronous FIFO holding captured {x, r} pairs; Depth must be a power of two.
module sqrt_host_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      unique case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/sqrt_host.sv
// Initiator for the sqrt unit: issues one operand at a time, waits for the result with a timeout,
// checks it and buffers {x, r} for downstream.
module sqrt_host
  import sqrt_host_pkg::*;
#(
  parameter int unsigned X_W     = DefXW,
  parameter int unsigned R_W     = DefRW,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [X_W-1:0] cmd_x_i,
  output logic [X_W-1:0] sqrt_x_o,
  output logic           sqrt_valid_o,
  input  logic           sqrt_ready_i,
  input  logic           sqrt_rvalid_i,
  output logic           sqrt_rready_o,
  input  logic [R_W-1:0] sqrt_r_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [X_W-1:0] out_x_o,
  output logic [R_W-1:0] out_r_o,
  output logic           timeout_o,
  output logic           check_fail_o,
  output logic           busy_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT);
  localparam int unsigned MulW = 2 * R_W + 2;
  localparam int unsigned EntW = X_W + R_W;

  state_t          state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [TmrW-1:0] timer_q, timer_d;

  logic            cmd_ready, sqrt_valid, sqrt_rready, push, timeout, check_fail;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic [EntW-1:0] fifo_rdata;

  // Result check: r*r <= x < (r+1)*(r+1), evaluated wide enough that nothing truncates.
  logic [MulW-1:0] r_ext, r_inc, x_ext, sq_lo, sq_hi;
  logic            r_bad;

  assign r_ext = MulW'(sqrt_r_i);
  assign r_inc = r_ext + MulW'(1);
  assign x_ext = MulW'(x_q);
  assign sq_lo = r_ext * r_ext;
  assign sq_hi = r_inc * r_inc;
  assign r_bad = (sq_lo > x_ext) || (sq_hi <= x_ext);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    timer_d     = timer_q;
    cmd_ready   = 1'b0;
    sqrt_valid  = 1'b0;
    sqrt_rready = 1'b0;
    push        = 1'b0;
    timeout     = 1'b0;
    check_fail  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Accepting only with a free slot means the capture push can never overflow.
        cmd_ready = (fifo_count < CntW'(DEPTH));
        if (cmd_valid_i && cmd_ready) begin
          x_d     = cmd_x_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        sqrt_valid = 1'b1;
        if (sqrt_ready_i) begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        sqrt_rready = 1'b1;
        if (sqrt_rvalid_i) begin
          push       = 1'b1;
          check_fail = r_bad;
          state_d    = StIdle;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      timer_q <= timer_d;
    end
  end

  sqrt_host_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push && !fifo_full),
    .pop_i   (out_ready_i),
    .data_i  ({x_q, sqrt_r_i}),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Every output is forced low while reset is held.
  assign cmd_ready_o   = cmd_ready && !rst_i;
  assign sqrt_x_o      = rst_i ? '0 : x_q;
  assign sqrt_valid_o  = sqrt_valid && !rst_i;
  assign sqrt_rready_o = sqrt_rready && !rst_i;
  assign out_valid_o   = !fifo_empty && !rst_i;
  assign out_x_o       = rst_i ? '0 : fifo_rdata[EntW-1:R_W];
  assign out_r_o       = rst_i ? '0 : fifo_rdata[R_W-1:0];
  assign timeout_o     = timeout && !rst_i;
  assign check_fail_o  = check_fail && !rst_i;
  assign busy_o        = (state_q != StIdle) && !rst_i;

endmodule

// File: tb/tb_sqrt_host.sv
// Bench for sqrt_host: behavioural sqrt unit on one side, scoreboard on the FIFO output.
module tb_sqrt_host;
  import sqrt_host_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i, cmd_ready_o;
  logic [7:0] cmd_x_i, sqrt_x_o, out_x_o;
  logic       sqrt_valid_o, sqrt_ready_i, sqrt_rvalid_i, sqrt_rready_o;
  logic [3:0] sqrt_r_i, out_r_o;
  logic       out_valid_o, out_ready_i, timeout_o, check_fail_o, busy_o;

  always #5 clk = ~clk;

  sqrt_host dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_x_i       (cmd_x_i),
    .sqrt_x_o      (sqrt_x_o),
    .sqrt_valid_o  (sqrt_valid_o),
    .sqrt_ready_i  (sqrt_ready_i),
    .sqrt_rvalid_i (sqrt_rvalid_i),
    .sqrt_rready_o (sqrt_rready_o),
    .sqrt_r_i      (sqrt_r_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_x_o       (out_x_o),
    .out_r_o       (out_r_o),
    .timeout_o     (timeout_o),
    .check_fail_o  (check_fail_o),
    .busy_o        (busy_o)
  );

  int     n_checks = 0;
  int     n_pass = 0;
  entry_t sb[$];

  int         model_lat = 3;
  bit         model_drop = 1'b0;
  int         model_force = -1;
  int         model_stall = 0;
  int         pend = 0;
  logic [7:0] pend_x = '0;

  int n_fail_pulse = 0;
  int n_to_pulse = 0;
  int wait_cyc = 0;

  function automatic logic [3:0] isqrt(input logic [7:0] x);
    int xi = int'(x);
    int r = 0;
    while ((r + 1) * (r + 1) <= xi) r++;
    return 4'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Behavioural sqrt unit: accepts on valid&ready, answers model_lat cycles later.
  initial begin
    sqrt_ready_i  = 1'b1;
    sqrt_rvalid_i = 1'b0;
    sqrt_r_i      = '0;
    forever begin
      @(negedge clk);
      sqrt_rvalid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !model_drop) begin
          sqrt_rvalid_i = 1'b1;
          sqrt_r_i      = (model_force >= 0) ? 4'(model_force) : isqrt(pend_x);
        end
      end
      if (sqrt_valid_o && model_stall > 0) begin
        sqrt_ready_i = 1'b0;
        model_stall--;
      end else begin
        sqrt_ready_i = 1'b1;
      end
      if (sqrt_valid_o && sqrt_ready_i) begin
        pend   = model_lat;
        pend_x = sqrt_x_o;
      end
    end
  end

  // Output monitor: pulse counting, timeout position and scoreboard compare on pop.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sqrt_valid_o) wait_cyc = 0;
      if (sqrt_rready_o) wait_cyc++;
      if (check_fail_o) n_fail_pulse++;
      if (timeout_o) begin
        n_to_pulse++;
        check("timeout_cycle", wait_cyc, 64);
      end
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_x", out_x_o, e.x);
          check("out_r", out_r_o, e.r);
        end
      end
    end
  end

  task automatic send(input logic [7:0] x, input bit exp_out);
    entry_t e;
    int     n = 0;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_x_i     = x;
    #2;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("cmd_accept", cmd_ready_o, 1);
    if (exp_out) begin
      e.x = x;
      e.r = (model_force >= 0) ? 4'(model_force) : isqrt(x);
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (busy_o && n < 300);
    check("idle", busy_o, 0);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    out_ready_i = 1'b1;
    #2;
    while (out_valid_o && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    out_ready_i = 1'b0;
    check("drain_empty", out_valid_o, 0);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_x_i     = '0;
    out_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    check("rst_flags", {cmd_ready_o, sqrt_valid_o, sqrt_rready_o, out_valid_o,
                        timeout_o, check_fail_o, busy_o}, 0);
    check("rst_data", {sqrt_x_o, out_x_o, out_r_o}, 0);
    @(negedge clk);
    rst_i = 1'b0;
    #2;
    check("post_rst_ready", cmd_ready_o, 1);
    check("post_rst_state", {busy_o, out_valid_o, sqrt_x_o}, 0);

    // x=0 with a slow unit
    model_lat = 10;
    send(8'd0, 1'b1);
    wait_idle();
    check("t1_pulses", {n_fail_pulse[7:0], n_to_pulse[7:0]}, 0);
    drain();

    // Back-to-back ordering
    model_lat = 3;
    send(8'd255, 1'b1);
    send(8'd16, 1'b1);
    wait_idle();
    check("t2_fail", n_fail_pulse, 0);
    drain();

    // Fill the FIFO; a fifth command must wait for a pop
    model_lat = 2;
    for (int i = 1; i <= 4; i++) send(8'(i * 37), 1'b1);
    wait_idle();
    check("full_noready", cmd_ready_o, 0);
    check("full_valid", out_valid_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_x_i     = 8'd100;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("full_hold", cmd_ready_o, 0);
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    #2;
    check("ready_after_pop", cmd_ready_o, 1);
    begin
      entry_t e;
      e.x = 8'd100;
      e.r = isqrt(8'd100);
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    wait_idle();
    drain();

    // Unit never answers
    model_drop = 1'b1;
    send(8'd50, 1'b0);
    wait_idle();
    model_drop = 1'b0;
    check("t4_timeouts", n_to_pulse, 1);
    check("t4_empty", out_valid_o, 0);

    // Wrong result is flagged but still buffered
    model_force = 5;
    send(8'd16, 1'b1);
    wait_idle();
    model_force = -1;
    check("t5_fail", n_fail_pulse, 1);
    drain();

    // Reset during WAIT; the late result must be ignored
    model_lat = 3;
    send(8'd9, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!sqrt_rready_o && n < 50);
    check("t6_in_wait", sqrt_rready_o, 1);
    @(negedge clk);
    rst_i = 1'b1;
    #2;
    check("t6_rst_flags", {cmd_ready_o, sqrt_valid_o, sqrt_rready_o, out_valid_o,
                           timeout_o, check_fail_o, busy_o}, 0);
    @(negedge clk);
    rst_i = 1'b0;
    #2;
    check("t6_rvalid_seen", sqrt_rvalid_i, 1);
    check("t6_idle", {busy_o, sqrt_rready_o}, 0);
    @(negedge clk);
    #2;
    check("t6_empty", out_valid_o, 0);
    check("t6_fail", n_fail_pulse, 1);

    // Stalled ISSUE holds request stable
    model_stall = 5;
    send(8'd77, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      check("t7_valid", sqrt_valid_o, 1);
      check("t7_x", sqrt_x_o, 77);
    end
    wait_idle();
    drain();
    check("final_timeouts", n_to_pulse, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
